button_conditioner: RTL and testbench
=====================================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DB_CYCLES, default 500000, SHALL set the number of consecutive stable cycles needed to accept a button level change (minimum 2).
REQ-002 Parameter HOLD_CYCLES, default 100000000, SHALL set the number of consecutive debounced-high cycles of clear that count as a long press (minimum 2).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 enter  input  1  SHALL be the raw, asynchronous enter pushbutton level.
REQ-006 clear  input  1  SHALL be the raw, asynchronous clear pushbutton level.
REQ-007 change  input  1  SHALL be the raw, asynchronous change pushbutton level.
REQ-008 switch  input  4  SHALL be the raw, asynchronous digit-select slide switches.
REQ-009 enter_p  output  1  SHALL be a one-cycle pulse per accepted enter press.
REQ-010 clear_p  output  1  SHALL be a one-cycle pulse per accepted clear press.
REQ-011 change_p  output  1  SHALL be a one-cycle pulse per accepted change press.
REQ-012 clear_hold  output  1  SHALL be a one-cycle pulse when clear has been held for HOLD_CYCLES.
REQ-013 digit  output  4  SHALL hold the switch value captured at the last accepted enter.
REQ-014 digit_valid  output  1  SHALL be a one-cycle pulse marking a new digit capture.

Function
REQ-015 Each button and each switch bit SHALL pass through a two-flop synchronizer before any other logic.
REQ-016 Each button SHALL own a debounced level db (reset 0) and a stability counter of width clog2(DB_CYCLES).
REQ-017 When the synchronized level equals db, the counter SHALL clear to 0.
REQ-018 When the levels differ and the counter is below DB_CYCLES-1, the counter SHALL increment.
REQ-019 When the levels differ and the counter equals DB_CYCLES-1, db SHALL take the synchronized level and the counter SHALL clear.
REQ-020 A glitch shorter than DB_CYCLES synchronized cycles SHALL leave db unchanged.
REQ-021 Each *_p output SHALL be registered and high for exactly one cycle, on the cycle after the db 0->1 transition; a db 1->0 transition SHALL produce no pulse.
REQ-022 Latency: a clean raw rising level first sampled at edge 1 SHALL produce the *_p pulse after edge DB_CYCLES+3 and no earlier.
REQ-023 A held button SHALL produce exactly one pulse, regardless of hold duration.
REQ-024 The hold counter SHALL count cycles while db_clear is 1, saturate at HOLD_CYCLES, and clear when db_clear is 0.
REQ-025 clear_hold SHALL pulse once, in the cycle the hold counter reaches HOLD_CYCLES, and SHALL NOT repeat until clear is released and pressed again.
REQ-026 Priority: if the enter and clear pulses would occur in the same cycle, clear_p SHALL assert and enter_p, digit_valid and the digit update SHALL be suppressed for that press.
REQ-027 change_p SHALL be independent of the other pulses and may coincide with them.
REQ-028 On every asserted enter_p, digit SHALL load the synchronized switch value and digit_valid SHALL assert in the same cycle as enter_p.
REQ-029 Between captures, digit SHALL hold its value; switch movement SHALL NOT alter digit.

Reset
REQ-030 Reset SHALL clear to 0: synchronizers, all db levels, stability counters, the hold counter, enter_p, clear_p, change_p, clear_hold, digit and digit_valid.
REQ-031 Reset asserted mid-debounce or mid-hold SHALL abort the operation, with no pulse emitted in that cycle or the next.
REQ-032 A button held high through reset release SHALL be treated as a new press: one pulse DB_CYCLES+3 edges after release.

Verification (DB_CYCLES=4, HOLD_CYCLES=8)
REQ-033 Raw enter rises cleanly with switch=4'h9 -> enter_p and digit_valid are high only in the cycle after edge 7; digit=4'h9 thereafter.
REQ-034 Enter bounces 1-0-1-0 at 1-cycle intervals, then is stable high -> exactly one enter_p, timed from the last rising bounce.
REQ-035 Clear held for 20 cycles -> one clear_p, then one clear_hold 8 cycles after db_clear rises; release and re-press -> both pulses repeat once.
REQ-036 Enter and clear rise on the same edge -> clear_p asserts; enter_p and digit_valid stay 0; digit is unchanged.
REQ-037 Reset pulsed at debounce count 2 with enter held -> no pulse during reset; one enter_p 7 edges after reset deasserts; all outputs read 0 during reset.
REQ-038 Switch changes to 4'h3 with no enter -> digit keeps its old value and digit_valid stays 0.

Source files
------------

// File: rtl/button_conditioner_if.sv
// Button conditioner bus: raw pushbutton/switch levels in, conditioned pulses out.
// master drives enter/clear/change/switch and observes the outputs; slave is the conditioner.
interface button_conditioner_if;
    logic       enter;
    logic       clear;
    logic       change;
    logic [3:0] switch;
    logic       enter_p;
    logic       clear_p;
    logic       change_p;
    logic       clear_hold;
    logic [3:0] digit;
    logic       digit_valid;

    modport master (
        output enter, clear, change, switch,
        input  enter_p, clear_p, change_p, clear_hold, digit, digit_valid
    );

    modport slave (
        input  enter, clear, change, switch,
        output enter_p, clear_p, change_p, clear_hold, digit, digit_valid
    );
endinterface

// File: rtl/button_conditioner.sv
// Synchronizes and debounces three pushbuttons plus a 4-bit switch bank,
// emitting one-cycle press pulses, a long-press pulse on clear, and digit capture.
// Ports: clk, reset (sync, active-high), bus (slave: raw levels in, pulses/digit out).
module button_conditioner #(
    parameter int DB_CYCLES   = 500000,
    parameter int HOLD_CYCLES = 100000000
) (
    input  logic                 clk,
    input  logic                 reset,
    button_conditioner_if.slave  bus
);

    localparam int CW = $clog2(DB_CYCLES);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DB_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_PRE = HW'(HOLD_CYCLES - 1);

    // Button index: 0 = enter, 1 = clear, 2 = change
    logic [2:0]    raw;
    logic [2:0]    sync1_q, sync2_q;
    logic [3:0]    sw1_q, sw2_q;
    logic [2:0]    db_q, db_d, db_dly_q;
    logic [CW-1:0] cnt_q [3];
    logic [CW-1:0] cnt_d [3];
    logic [HW-1:0] hold_q, hold_d;
    logic [2:0]    rise;
    logic          hold_hit;
    logic          enter_ok;

    logic          enter_p_q, clear_p_q, change_p_q, clear_hold_q;
    logic [3:0]    digit_q, digit_d;
    logic          digit_valid_q;

    assign raw = {bus.change, bus.clear, bus.enter};

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            db_d[i]  = db_q[i];
            cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    db_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // db_dly lags db by one cycle, so rising edges pulse the cycle after db rises
    assign rise = db_q & ~db_dly_q;

    always_comb begin
        hold_d = '0;
        if (db_q[1]) begin
            hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
        end
    end

    // Saturation guarantees this fires only once per press
    assign hold_hit = db_q[1] && (hold_q == HOLD_PRE);

    // A coincident clear press swallows the enter press
    assign enter_ok = rise[0] & ~rise[1];

    assign digit_d = enter_ok ? sw2_q : digit_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            sw1_q         <= '0;
            sw2_q         <= '0;
            db_q          <= '0;
            db_dly_q      <= '0;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= '0;
            end
            hold_q        <= '0;
            enter_p_q     <= 1'b0;
            clear_p_q     <= 1'b0;
            change_p_q    <= 1'b0;
            clear_hold_q  <= 1'b0;
            digit_q       <= '0;
            digit_valid_q <= 1'b0;
        end else begin
            sync1_q       <= raw;
            sync2_q       <= sync1_q;
            sw1_q         <= bus.switch;
            sw2_q         <= sw1_q;
            db_q          <= db_d;
            db_dly_q      <= db_q;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            hold_q        <= hold_d;
            enter_p_q     <= enter_ok;
            clear_p_q     <= rise[1];
            change_p_q    <= rise[2];
            clear_hold_q  <= hold_hit;
            digit_q       <= digit_d;
            digit_valid_q <= enter_ok;
        end
    end

    assign bus.enter_p     = enter_p_q;
    assign bus.clear_p     = clear_p_q;
    assign bus.change_p    = change_p_q;
    assign bus.clear_hold  = clear_hold_q;
    assign bus.digit       = digit_q;
    assign bus.digit_valid = digit_valid_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DB_CYCLES=4, HOLD_CYCLES=8.
// Per-cycle vector table plus hand-written bounce, long-press and reset sequences.
module tb_button_conditioner;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    button_conditioner_if bus ();

    button_conditioner #(
        .DB_CYCLES  (4),
        .HOLD_CYCLES(8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       en;
        logic       cl;
        logic       ch;
        logic [3:0] sw;
        logic [8:0] exp;
    } vec_t;

    vec_t vq[$];

    function automatic logic [8:0] ex(input logic ep, input logic cp,
                                      input logic chp, input logic hd,
                                      input logic dv, input logic [3:0] dg);
        return {ep, cp, chp, hd, dv, dg};
    endfunction

    function automatic logic [8:0] got_out();
        return {bus.enter_p, bus.clear_p, bus.change_p, bus.clear_hold,
                bus.digit_valid, bus.digit};
    endfunction

    task automatic add(input int n, input logic r, input logic e,
                       input logic c, input logic h, input logic [3:0] sw,
                       input logic [8:0] exv);
        vec_t v;
        v.rst = r; v.en = e; v.cl = c; v.ch = h; v.sw = sw; v.exp = exv;
        for (int k = 0; k < n; k++) vq.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input int idx,
                         input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s[%0d] got=%0h want=%0h", nm, idx, got, want);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.enter = 0; bus.clear = 0; bus.change = 0; bus.switch = 4'h0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic clear_press(output int ncp, output int tcp,
                               output int nh, output int th);
        ncp = 0; tcp = -1; nh = 0; th = -1;
        for (int i = 1; i <= 32; i++) begin
            bus.clear = (i <= 20);
            tick();
            if (bus.clear_p) begin ncp++; tcp = i; end
            if (bus.clear_hold) begin nh++; th = i; end
        end
    endtask

    initial begin
        int n_ep, t_ep, n_dv, ncp, tcp, nh, th;
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.enter = 0; bus.clear = 0; bus.change = 0; bus.switch = 4'h0;

        // reset state
        add(2, 1, 0, 0, 0, 4'h0, ex(0, 0, 0, 0, 0, 4'h0));
        // clean enter press with switch = 9
        add(6, 0, 1, 0, 0, 4'h9, ex(0, 0, 0, 0, 0, 4'h0));
        add(1, 0, 1, 0, 0, 4'h9, ex(1, 0, 0, 0, 1, 4'h9));
        add(3, 0, 1, 0, 0, 4'h9, ex(0, 0, 0, 0, 0, 4'h9));
        add(8, 0, 0, 0, 0, 4'h9, ex(0, 0, 0, 0, 0, 4'h9));
        // switch moves without enter
        add(8, 0, 0, 0, 0, 4'h3, ex(0, 0, 0, 0, 0, 4'h9));
        // change press
        add(6, 0, 0, 0, 1, 4'h3, ex(0, 0, 0, 0, 0, 4'h9));
        add(1, 0, 0, 0, 1, 4'h3, ex(0, 0, 1, 0, 0, 4'h9));
        add(3, 0, 0, 0, 1, 4'h3, ex(0, 0, 0, 0, 0, 4'h9));
        add(8, 0, 0, 0, 0, 4'h3, ex(0, 0, 0, 0, 0, 4'h9));
        // enter and clear together: clear wins, digit untouched
        add(6, 0, 1, 1, 0, 4'h3, ex(0, 0, 0, 0, 0, 4'h9));
        add(1, 0, 0, 0, 0, 4'h3, ex(0, 1, 0, 0, 0, 4'h9));
        add(12, 0, 0, 0, 0, 4'h3, ex(0, 0, 0, 0, 0, 4'h9));

        foreach (vq[i]) begin
            reset      = vq[i].rst;
            bus.enter  = vq[i].en;
            bus.clear  = vq[i].cl;
            bus.change = vq[i].ch;
            bus.switch = vq[i].sw;
            tick();
            check("vec", i, int'(got_out()), int'(vq[i].exp));
        end

        // bounce 1-0-1-0 then stable high; last rise sampled at edge 5
        do_reset();
        bus.switch = 4'h6;
        n_ep = 0; t_ep = -1; n_dv = 0;
        for (int i = 1; i <= 30; i++) begin
            bus.enter = (i == 1 || i == 3 || i >= 5);
            tick();
            if (bus.enter_p) begin n_ep++; t_ep = i; end
            if (bus.digit_valid) n_dv++;
        end
        check("bounce_count", 0, n_ep, 1);
        check("bounce_edge", 0, t_ep, 11);
        check("bounce_dv", 0, n_dv, 1);
        check("bounce_digit", 0, int'(bus.digit), 6);

        // long press of clear, twice
        do_reset();
        for (int p = 0; p < 2; p++) begin
            clear_press(ncp, tcp, nh, th);
            check("hold_cp_count", p, ncp, 1);
            check("hold_cp_edge", p, tcp, 7);
            check("hold_count", p, nh, 1);
            check("hold_edge", p, th, 14);
        end

        // reset mid-debounce with enter held through release
        do_reset();
        bus.switch = 4'h5;
        bus.enter  = 1'b1;
        n_ep = 0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            if (bus.enter_p || bus.digit_valid) n_ep++;
        end
        check("pre_rst_pulse", 0, n_ep, 0);
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("in_rst_outs", i, int'(got_out()), 0);
        end
        reset = 1'b0;
        n_ep = 0; t_ep = -1;
        for (int i = 1; i <= 14; i++) begin
            tick();
            if (bus.enter_p) begin n_ep++; t_ep = i; end
        end
        check("rst_rel_count", 0, n_ep, 1);
        check("rst_rel_edge", 0, t_ep, 7);
        check("rst_rel_digit", 0, int'(bus.digit), 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
